// File: rtl/byp_ctrl_pkg.sv
// rtl/byp_ctrl_pkg.sv - shared widths, R0 constant and pipeline stage record for byp_ctrl
package byp_ctrl_pkg;

    localparam int REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] R0_ADDR = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  we;
        logic                  ld;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{dst: '0, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/byp_ctrl_cmp.sv
// rtl/byp_ctrl_cmp.sv - per-port producer comparator (EX match, DM match, load hit)
module byp_cmp
    import byp_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  re,
    input  stage_t                ex_stage,
    input  logic [REG_ADDR_W-1:0] dm_dst,
    input  logic                  dm_we,
    output logic                  match_ex,
    output logic                  match_dm,
    output logic                  ld_hit
);

    logic live;

    // R0 is hardwired to zero, so it never creates a dependency
    assign live     = re && (addr != R0_ADDR);
    assign match_ex = live && ex_stage.we && (ex_stage.dst == addr);
    assign match_dm = live && dm_we && (dm_dst == addr);
    assign ld_hit   = match_ex && ex_stage.ld;

endmodule

// File: rtl/byp_ctrl.sv
// rtl/byp_ctrl.sv - bypass select and hazard stall control; BYPASS_EN enables forwarding
module byp_ctrl #(
    parameter int REG_ADDR_W = byp_ctrl_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] p0_addr,
    input  logic [REG_ADDR_W-1:0] p1_addr,
    input  logic                  re0,
    input  logic                  re1,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    input  logic                  rf_we,
    input  logic                  ld,
    input  logic                  flush,
    input  logic                  stall_ID_EX,
    input  logic                  stall_EX_DM,
    input  logic                  stall_DM_WB,
    output logic                  byp0_EX,
    output logic                  byp0_DM,
    output logic                  byp1_EX,
    output logic                  byp1_DM,
    output logic                  hzd_stall
);

    import byp_ctrl_pkg::*;

    stage_t id_ex, ex_dm, dm_wb;
    logic   ex0, dm0, lh0, ex1, dm1, lh1;
    logic   hzd_raw, bubble;

    byp_cmp u_cmp0 (
        .addr     (p0_addr),
        .re       (re0),
        .ex_stage (id_ex),
        .dm_dst   (ex_dm.dst),
        .dm_we    (ex_dm.we),
        .match_ex (ex0),
        .match_dm (dm0),
        .ld_hit   (lh0)
    );

    byp_cmp u_cmp1 (
        .addr     (p1_addr),
        .re       (re1),
        .ex_stage (id_ex),
        .dm_dst   (ex_dm.dst),
        .dm_we    (ex_dm.we),
        .match_ex (ex1),
        .match_dm (dm1),
        .ld_hit   (lh1)
    );

`ifdef BYPASS_EN
    assign hzd_raw = lh0 || lh1;
`else
    // No forwarding: wait until the producer has left EX_DM and the RF writes through
    assign hzd_raw = ex0 || dm0 || ex1 || dm1;
`endif

    assign hzd_stall = hzd_raw && !flush;
    assign bubble    = flush || hzd_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex <= STAGE_BUBBLE;
            ex_dm <= STAGE_BUBBLE;
            dm_wb <= STAGE_BUBBLE;
        end else begin
            if (!stall_ID_EX)
                id_ex <= bubble ? STAGE_BUBBLE : stage_t'{dst: dst_addr, we: rf_we, ld: ld};
            if (!stall_EX_DM)
                ex_dm <= id_ex;
            if (!stall_DM_WB)
                dm_wb <= ex_dm;
        end
    end

`ifdef BYPASS_EN
    logic [3:0] byp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byp_q <= 4'b0;
        else if (!stall_ID_EX)
            byp_q <= bubble ? 4'b0 : {ex0, dm0, ex1, dm1};
    end

    assign {byp0_EX, byp0_DM, byp1_EX, byp1_DM} = byp_q;

    // DM_WB is tracked for pipeline completeness; the RF write-through covers it
    logic unused_bits;
    assign unused_bits = ^dm_wb;
`else
    assign {byp0_EX, byp0_DM, byp1_EX, byp1_DM} = 4'b0;

    logic unused_bits;
    assign unused_bits = ^{dm_wb, lh0, lh1};
`endif

endmodule
